// File: rtl/gf_mul_seq.sv
// gf_mul_seq: sequential GF(2^M) arithmetic unit.
//   Digit-serial MSB-first multiplier (D bits of operand B per cycle) with an
//   inverse mode that computes a^(2^M-2) by alternating square / multiply
//   passes on the same kernel.
// Parameters:
//   M     field width in bits (2..16)
//   POLY  reduction polynomial, M+1 bits, bit M set
//   D     digits per cycle, must divide M
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     request, sampled only when idle
//   op        0 = multiply a*b, 1 = inverse of a
//   a, b      operands, captured on accepted start
//   busy      operation in progress
//   done      one-cycle pulse, y valid
//   y         result, held until next done
//   zero_err  inverse requested for a = 0; held with y
module gf_mul_seq #(
  parameter int unsigned M    = 8,
  parameter logic [M:0]  POLY = 9'h11D,
  parameter int unsigned D    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] y,
  output logic         zero_err
);

  localparam int unsigned Steps = M / D;
  localparam int unsigned CntW  = $clog2(M + 1);
  localparam logic [M-1:0]    Red      = POLY[M-1:0];
  localparam logic [CntW-1:0] LastStep = CntW'(Steps - 1);
  localparam logic [CntW-1:0] LastIter = CntW'(M - 1);

  typedef enum logic [1:0] {StIdle, StMul, StInvSq, StInvMl} state_e;

  state_e          state_q, state_d;
  logic [M-1:0]    acc_q, acc_d;
  logic [M-1:0]    op_a_q, op_a_d;
  logic [M-1:0]    op_b_q, op_b_d;   // shifts left; top D bits are the current digit
  logic [M-1:0]    s_q, s_d;
  logic [M-1:0]    r_q, r_d;
  logic [CntW-1:0] step_q, step_d;
  logic [CntW-1:0] iter_q, iter_d;
  logic [M-1:0]    y_q, y_d;
  logic            zero_err_q, zero_err_d;
  logic            done_q, done_d;

  logic [M-1:0]    acc_step;
  logic            last_step;

  // Multiply by x modulo POLY.
  function automatic logic [M-1:0] mul_x(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? Red : '0);
  endfunction

  // One kernel cycle: D Horner steps, MSB of the digit first.
  always_comb begin
    acc_step = acc_q;
    for (int unsigned k = 0; k < D; k++) begin
      acc_step = mul_x(acc_step) ^ (op_b_q[M-1-k] ? op_a_q : '0);
    end
  end

  assign last_step = (step_q == LastStep);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    s_d        = s_q;
    r_d        = r_q;
    step_d     = step_q;
    iter_d     = iter_q;
    y_d        = y_q;
    zero_err_d = zero_err_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_a_d = a;
          acc_d  = '0;
          step_d = '0;
          if (op) begin
            // First inverse pass squares a.
            s_d     = a;
            r_d     = M'(1);
            op_b_d  = a;
            iter_d  = CntW'(1);
            state_d = StInvSq;
          end else begin
            op_b_d  = b;
            state_d = StMul;
          end
        end
      end

      StMul: begin
        acc_d  = acc_step;
        op_b_d = op_b_q << D;
        step_d = step_q + CntW'(1);
        if (last_step) begin
          y_d        = acc_step;
          zero_err_d = 1'b0;
          done_d     = 1'b1;
          state_d    = StIdle;
        end
      end

      StInvSq: begin
        acc_d  = acc_step;
        op_b_d = op_b_q << D;
        step_d = step_q + CntW'(1);
        if (last_step) begin
          // s = s^2 done; next pass r = r * s.
          s_d     = acc_step;
          op_a_d  = r_q;
          op_b_d  = acc_step;
          acc_d   = '0;
          step_d  = '0;
          state_d = StInvMl;
        end
      end

      StInvMl: begin
        acc_d  = acc_step;
        op_b_d = op_b_q << D;
        step_d = step_q + CntW'(1);
        if (last_step) begin
          r_d    = acc_step;
          acc_d  = '0;
          step_d = '0;
          if (iter_q == LastIter) begin
            // Nonzero a always has a nonzero inverse, so r = 0 means a = 0.
            y_d        = acc_step;
            zero_err_d = (acc_step == '0);
            done_d     = 1'b1;
            state_d    = StIdle;
          end else begin
            iter_d  = iter_q + CntW'(1);
            op_a_d  = s_q;
            op_b_d  = s_q;
            state_d = StInvSq;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      s_q        <= '0;
      r_q        <= '0;
      step_q     <= '0;
      iter_q     <= '0;
      y_q        <= '0;
      zero_err_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      s_q        <= s_d;
      r_q        <= r_d;
      step_q     <= step_d;
      iter_q     <= iter_d;
      y_q        <= y_d;
      zero_err_q <= zero_err_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign y        = y_q;
  assign zero_err = zero_err_q;

endmodule

// File: tb/tb_gf_mul_seq.sv
// Testbench for gf_mul_seq. Five instances run side by side:
//   0..3 : M=8, POLY=11D, D=1,2,4,8
//   4    : M=4, POLY=13,  D=2
// A transaction-level model (full carry-less product + long division,
// brute-force inverse, latency countdown) predicts busy/done/y/zero_err and is
// compared against every instance on every cycle. Directed runs add literal
// expectations for values and latencies.
module tb_gf_mul_seq;

  localparam int NI = 5;
  localparam int RandCycles = 25000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]      rst_v, start_v, op_v;
  logic [NI-1:0][7:0] a_v, b_v;
  wire  [NI-1:0]      busy_v, done_v, ze_v;
  wire  [NI-1:0][7:0] y_v;

  for (genvar g = 0; g < 4; g++) begin : g_m8
    gf_mul_seq #(.M(8), .POLY(9'h11D), .D(1 << g)) u_dut (
      .clk(clk), .rst(rst_v[g]), .start(start_v[g]), .op(op_v[g]),
      .a(a_v[g]), .b(b_v[g]), .busy(busy_v[g]), .done(done_v[g]),
      .y(y_v[g]), .zero_err(ze_v[g])
    );
  end

  gf_mul_seq #(.M(4), .POLY(5'h13), .D(2)) u_dut4 (
    .clk(clk), .rst(rst_v[4]), .start(start_v[4]), .op(op_v[4]),
    .a(a_v[4][3:0]), .b(b_v[4][3:0]), .busy(busy_v[4]), .done(done_v[4]),
    .y(y_v[4][3:0]), .zero_err(ze_v[4])
  );
  assign y_v[4][7:4] = 4'h0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string what, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s inst%0d @%0t: got %0h expected %0h", what, k, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_of(input int k);
    return (k == 4) ? 4 : 8;
  endfunction
  function automatic int d_of(input int k);
    return (k == 4) ? 2 : (1 << k);
  endfunction
  function automatic int poly_of(input int k);
    return (k == 4) ? 'h13 : 'h11D;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z, input int k);
    int m = m_of(k);
    int p = poly_of(k);
    int prod = 0;
    int xa = int'(x) & ((1 << m) - 1);
    int zb = int'(z) & ((1 << m) - 1);
    for (int i = 0; i < m; i++) if (zb[i]) prod ^= xa << i;
    for (int i = 2 * m - 2; i >= m; i--) if (prod[i]) prod ^= p << (i - m);
    return prod[7:0];
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x, input int k);
    int m = m_of(k);
    logic [7:0] xm = x & 8'((1 << m) - 1);
    if (xm == 8'h00) return 8'h00;
    for (int c = 1; c < (1 << m); c++) if (gmul(xm, 8'(c), k) == 8'h01) return 8'(c);
    return 8'h00;
  endfunction

  int         m_left [NI];
  logic       m_busy [NI], m_done [NI], m_ze [NI], m_rze [NI];
  logic [7:0] m_y [NI], m_res [NI];
  int         n_ops [NI];

  initial for (int k = 0; k < NI; k++) n_ops[k] = 0;

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst_v[k]) begin
        m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_y[k] <= 8'h00; m_ze[k] <= 1'b0;
        m_left[k] <= 0;
      end else begin
        m_done[k] <= 1'b0;
        if (m_busy[k]) begin
          if (m_left[k] == 1) begin
            m_busy[k] <= 1'b0; m_done[k] <= 1'b1;
            m_y[k] <= m_res[k]; m_ze[k] <= m_rze[k];
            n_ops[k] <= n_ops[k] + 1;
          end else begin
            m_left[k] <= m_left[k] - 1;
          end
        end else if (start_v[k]) begin
          m_busy[k] <= 1'b1;
          if (op_v[k]) begin
            m_left[k] <= 2 * (m_of(k) - 1) * m_of(k) / d_of(k);
            m_res[k]  <= ginv(a_v[k], k);
            m_rze[k]  <= ((a_v[k] & 8'((1 << m_of(k)) - 1)) == 8'h00);
          end else begin
            m_left[k] <= m_of(k) / d_of(k);
            m_res[k]  <= gmul(a_v[k], b_v[k], k);
            m_rze[k]  <= 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        check("busy", k, 32'(busy_v[k]), 32'(m_busy[k]));
        check("done", k, 32'(done_v[k]), 32'(m_done[k]));
        check("y", k, 32'(y_v[k]), 32'(m_y[k]));
        check("zero_err", k, 32'(ze_v[k]), 32'(m_ze[k]));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input int k, input bit o, input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] yv, output logic zv, output int lat);
    @(negedge clk);
    start_v[k] = 1'b1; op_v[k] = o; a_v[k] = av; b_v[k] = bv;
    @(posedge clk);
    #1;
    // Input changes after acceptance must not matter.
    start_v[k] = 1'b0; op_v[k] = ~o; a_v[k] = ~av; b_v[k] = ~bv;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk);
      lat++;
      #1;
      if (done_v[k]) break;
    end
    yv = y_v[k];
    zv = ze_v[k];
  endtask

  task automatic directed(input string name, input int k, input bit o, input logic [7:0] av,
                          input logic [7:0] bv, input logic [7:0] ey, input logic eze,
                          input int elat);
    logic [7:0] yv;
    logic       zv;
    int         lat;
    run_op(k, o, av, bv, yv, zv, lat);
    check({name, " y"}, k, 32'(yv), 32'(ey));
    check({name, " zero_err"}, k, 32'(zv), 32'(eze));
    check({name, " latency"}, k, 32'(lat), 32'(elat));
  endtask

  task automatic rand_drive(input int k);
    repeat (RandCycles) begin
      @(negedge clk);
      rst_v[k]   = ($urandom_range(0, 1499) == 0);
      start_v[k] = ($urandom_range(0, 3) != 0);
      op_v[k]    = $urandom_range(0, 1) == 1;
      a_v[k]     = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      b_v[k]     = 8'($urandom);
    end
    @(negedge clk);
    rst_v[k] = 1'b0;
    start_v[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] yi, yp;
    logic       zi;
    int         lat, t0, t1, cyc, ndone;

    rst_v = '1; start_v = '0; op_v = '0; a_v = '0; b_v = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 0, 32'(busy_v), 32'h0);
    check("reset done", 0, 32'(done_v), 32'h0);
    check("reset y", 0, 32'(y_v), 32'h0);
    rst_v = '0;
    chk_en = 1'b1;

    // Pin the model with hand-computed values.
    check("model mul 80*02", 0, 32'(gmul(8'h80, 8'h02, 0)), 32'h1D);
    check("model mul FF*01", 0, 32'(gmul(8'hFF, 8'h01, 0)), 32'hFF);
    check("model inv 02", 0, 32'(ginv(8'h02, 0)), 32'h8E);
    check("model m4 mul 8*2", 4, 32'(gmul(8'h08, 8'h02, 4)), 32'h3);
    check("model m4 inv 2", 4, 32'(ginv(8'h02, 4)), 32'h9);

    // M=8, D=1
    directed("d1 inv 00", 0, 1'b1, 8'h00, 8'h55, 8'h00, 1'b1, 112);
    directed("d1 mul 80*02", 0, 1'b0, 8'h80, 8'h02, 8'h1D, 1'b0, 8);
    directed("d1 mul FF*01", 0, 1'b0, 8'hFF, 8'h01, 8'hFF, 1'b0, 8);
    directed("d1 mul 00*37", 0, 1'b0, 8'h00, 8'h37, 8'h00, 1'b0, 8);
    directed("d1 inv 02", 0, 1'b1, 8'h02, 8'h00, 8'h8E, 1'b0, 112);
    directed("d1 inv 01", 0, 1'b1, 8'h01, 8'h00, 8'h01, 1'b0, 112);
    // M=8, D=2 and D=4
    directed("d2 mul 80*02", 1, 1'b0, 8'h80, 8'h02, 8'h1D, 1'b0, 4);
    directed("d2 inv 02", 1, 1'b1, 8'h02, 8'h00, 8'h8E, 1'b0, 56);
    directed("d4 mul 80*02", 2, 1'b0, 8'h80, 8'h02, 8'h1D, 1'b0, 2);
    directed("d4 inv 02", 2, 1'b1, 8'h02, 8'h00, 8'h8E, 1'b0, 28);
    // M=8, D=8
    directed("d8 mul 80*02", 3, 1'b0, 8'h80, 8'h02, 8'h1D, 1'b0, 1);
    directed("d8 mul FF*01", 3, 1'b0, 8'hFF, 8'h01, 8'hFF, 1'b0, 1);
    directed("d8 inv 02", 3, 1'b1, 8'h02, 8'h00, 8'h8E, 1'b0, 14);
    directed("d8 inv 00", 3, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 14);
    // M=4, POLY=13, D=2
    directed("m4 mul 8*2", 4, 1'b0, 8'h08, 8'h02, 8'h03, 1'b0, 2);
    directed("m4 inv 2", 4, 1'b1, 8'h02, 8'h00, 8'h09, 1'b0, 12);

    // a * inv(a) = 1 for every nonzero a (D=8).
    for (int av = 1; av < 256; av++) begin
      run_op(3, 1'b1, 8'(av), 8'h00, yi, zi, lat);
      run_op(3, 1'b0, 8'(av), yi, yp, zi, lat);
      check("a*inv(a)", 3, 32'(yp), 32'h01);
    end

    // Start held high: accepts every L+1 = 5 cycles (D=2 multiply).
    @(negedge clk);
    start_v[1] = 1'b1; op_v[1] = 1'b0; a_v[1] = 8'h03; b_v[1] = 8'h05;
    t0 = -1; t1 = -1;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      #1;
      if (done_v[1]) begin
        if (t0 < 0) t0 = cyc;
        else if (t1 < 0) t1 = cyc;
      end
    end
    @(negedge clk);
    start_v[1] = 1'b0;
    check("held start period", 1, 32'(t1 - t0), 32'd5);
    repeat (6) @(posedge clk);

    // Start pulses while busy are ignored.
    @(negedge clk);
    start_v[0] = 1'b1; op_v[0] = 1'b1; a_v[0] = 8'h02;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk);
      lat++;
      #1;
      if (done_v[0]) break;
      start_v[0] = (lat % 10 == 3);
      op_v[0] = 1'b0; a_v[0] = 8'hFF; b_v[0] = 8'hFF;
    end
    start_v[0] = 1'b0;
    check("busy-start y", 0, 32'(y_v[0]), 32'h8E);
    check("busy-start latency", 0, 32'(lat), 32'd112);

    // Reset mid-inverse aborts without done.
    @(negedge clk);
    start_v[0] = 1'b1; op_v[0] = 1'b1; a_v[0] = 8'h07;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_v[0] = 1'b1; start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[0] = 1'b0; start_v[0] = 1'b0;
    check("abort busy", 0, 32'(busy_v[0]), 32'h0);
    check("abort done", 0, 32'(done_v[0]), 32'h0);
    check("abort y", 0, 32'(y_v[0]), 32'h00);
    ndone = 0;
    repeat (120) begin
      @(posedge clk);
      #1;
      if (done_v[0]) ndone++;
    end
    check("abort no done", 0, 32'(ndone), 32'd0);
    directed("after abort mul", 0, 1'b0, 8'h80, 8'h02, 8'h1D, 1'b0, 8);

    // Random traffic on all instances in parallel.
    for (int k = 0; k < NI; k++) begin
      automatic int kk = k;
      fork
        rand_drive(kk);
      join_none
    end
    wait fork;
    repeat (120) @(posedge clk);
    for (int k = 0; k < NI; k++) check("random ops completed", k, 32'(n_ops[k] > 50), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
